// File: rtl/flash_sample_streamer.sv
// flash_sample_streamer: fetches 32-bit words from Avalon-MM flash and
// plays them out as SAMPLE_W-bit lanes, one lane per audio sample tick.
module flash_sample_streamer #(
   parameter int                ADDR_W     = 23,
   parameter int                SAMPLE_W   = 8,
   parameter logic [ADDR_W-1:0] START_ADDR = '0,
   parameter logic [ADDR_W-1:0] END_ADDR   = 23'h7FFFF
) (
   input  logic                inclk,
   input  logic                reset_n,
   input  logic                play,
   input  logic                direction,
   input  logic                loop,
   input  logic                restart,
   input  logic                sample_tick,
   output logic                flash_mem_read,
   output logic [ADDR_W-1:0]   flash_mem_address,
   output logic [3:0]          flash_mem_byteenable,
   input  logic                flash_mem_waitrequest,
   input  logic                flash_mem_readdatavalid,
   input  logic [31:0]         flash_mem_readdata,
   output logic [SAMPLE_W-1:0] audio_data,
   output logic                sample_valid,
   output logic                end_reached,
   output logic                underrun,
   output logic                busy
);

   localparam int N = 32 / SAMPLE_W;
   localparam int IDX_W = $clog2(N);
   localparam logic [IDX_W-1:0] IDX_FIRST = '0;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      PLAY,
      NEXT
   } state_t;

   state_t              state;
   state_t              state_nx;
   logic [ADDR_W-1:0]   addr;
   logic [ADDR_W-1:0]   addr_nx;
   logic [31:0]         word_buf;
   logic [IDX_W-1:0]    idx;
   logic [IDX_W-1:0]    idx_nx;
   logic                dir_r;
   logic                dir_nx;
   logic                rst_pend;
   logic                rst_pend_nx;
   logic [SAMPLE_W-1:0] audio_nx;
   logic                valid_nx;
   logic                end_nx;
   logic                under_nx;
   logic                load_word;
   logic [SAMPLE_W-1:0] lanes [N];

   for (genvar k = 0; k < N; k++) begin : g_lane
      assign lanes[k] = word_buf[k*SAMPLE_W +: SAMPLE_W];
   end

   assign flash_mem_read       = (state == REQ);
   assign flash_mem_address    = addr;
   assign flash_mem_byteenable = 4'hF;
   assign busy                 = (state != IDLE);

   always_ff @(posedge inclk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         addr         <= START_ADDR;
         word_buf     <= '0;
         idx          <= '0;
         dir_r        <= 1'b0;
         rst_pend     <= 1'b0;
         audio_data   <= '0;
         sample_valid <= 1'b0;
         end_reached  <= 1'b0;
         underrun     <= 1'b0;
      end else begin
         state        <= state_nx;
         addr         <= addr_nx;
         idx          <= idx_nx;
         dir_r        <= dir_nx;
         rst_pend     <= rst_pend_nx;
         audio_data   <= audio_nx;
         sample_valid <= valid_nx;
         end_reached  <= end_nx;
         underrun     <= under_nx;
         if (load_word) begin
            word_buf <= flash_mem_readdata;
         end
      end
   end

   always_comb begin
      state_nx    = state;
      addr_nx     = addr;
      idx_nx      = idx;
      dir_nx      = dir_r;
      rst_pend_nx = rst_pend;
      audio_nx    = audio_data;
      valid_nx    = 1'b0;
      end_nx      = 1'b0;
      under_nx    = 1'b0;
      load_word   = 1'b0;
      if (state != IDLE && restart) begin
         rst_pend_nx = 1'b1;
      end
      unique case (state)
         IDLE: begin
            if (restart) begin
               addr_nx = direction ? END_ADDR : START_ADDR;
            end
            if (play) begin
               state_nx = REQ;
            end
         end
         REQ: begin
            under_nx = sample_tick & play;
            if (!flash_mem_waitrequest) begin
               state_nx = WAIT;
            end
         end
         WAIT: begin
            under_nx = sample_tick & play;
            if (flash_mem_readdatavalid) begin
               load_word = 1'b1;
               dir_nx    = direction;
               idx_nx    = direction ? IDX_LAST : IDX_FIRST;
               state_nx  = PLAY;
            end
         end
         PLAY: begin
            if (sample_tick) begin
               audio_nx = lanes[idx];
               valid_nx = 1'b1;
               if (idx == (dir_r ? IDX_FIRST : IDX_LAST)) begin
                  state_nx = NEXT;
               end else begin
                  idx_nx = dir_r ? idx - IDX_ONE : idx + IDX_ONE;
               end
            end
         end
         NEXT: begin
            rst_pend_nx = 1'b0;
            state_nx    = play ? REQ : IDLE;
            // a restart arriving in NEXT itself is honoured immediately
            if (rst_pend || restart) begin
               addr_nx = direction ? END_ADDR : START_ADDR;
            end else if (!direction && addr == END_ADDR) begin
               addr_nx = START_ADDR;
               if (!loop) begin
                  end_nx   = 1'b1;
                  state_nx = IDLE;
               end
            end else if (direction && addr == START_ADDR) begin
               addr_nx = END_ADDR;
               if (!loop) begin
                  end_nx   = 1'b1;
                  state_nx = IDLE;
               end
            end else begin
               addr_nx = direction ? addr - ADDR_ONE : addr + ADDR_ONE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_flash_sample_streamer.sv
// tb_flash_sample_streamer: directed stimulus with a queue scoreboard
// for an 8-bit windowed streamer and a 16-bit full-range streamer.
`timescale 1ns/1ps
module tb_flash_sample_streamer;

   logic inclk = 1'b0;
   logic reset_n = 1'b1;
   always #5 inclk = ~inclk;

   logic        a_play = 0, a_dir = 0, a_loop = 1, a_restart = 0, a_tick = 0;
   logic        a_read, a_valid, a_end, a_under, a_busy;
   logic [22:0] a_addr;
   logic [3:0]  a_be;
   logic [7:0]  a_audio;

   logic        b_play = 0, b_dir = 0, b_loop = 1, b_restart = 0, b_tick = 0;
   logic        b_read, b_valid, b_end, b_under, b_busy;
   logic [22:0] b_addr;
   logic [3:0]  b_be;
   logic [15:0] b_audio;

   logic        f_wr, f_rdv;
   logic [31:0] f_rdata;
   logic        sel_b = 0;
   int          wait_n = 2;

   flash_sample_streamer #(
      .SAMPLE_W(8), .START_ADDR(23'd4), .END_ADDR(23'd6)
   ) u_a (
      .inclk(inclk), .reset_n(reset_n), .play(a_play),
      .direction(a_dir), .loop(a_loop), .restart(a_restart),
      .sample_tick(a_tick), .flash_mem_read(a_read),
      .flash_mem_address(a_addr), .flash_mem_byteenable(a_be),
      .flash_mem_waitrequest(f_wr),
      .flash_mem_readdatavalid(f_rdv),
      .flash_mem_readdata(f_rdata), .audio_data(a_audio),
      .sample_valid(a_valid), .end_reached(a_end),
      .underrun(a_under), .busy(a_busy)
   );

   flash_sample_streamer #(
      .SAMPLE_W(16)
   ) u_b (
      .inclk(inclk), .reset_n(reset_n), .play(b_play),
      .direction(b_dir), .loop(b_loop), .restart(b_restart),
      .sample_tick(b_tick), .flash_mem_read(b_read),
      .flash_mem_address(b_addr), .flash_mem_byteenable(b_be),
      .flash_mem_waitrequest(f_wr),
      .flash_mem_readdatavalid(f_rdv),
      .flash_mem_readdata(f_rdata), .audio_data(b_audio),
      .sample_valid(b_valid), .end_reached(b_end),
      .underrun(b_under), .busy(b_busy)
   );

   typedef struct packed {
      logic        is_end;
      logic [22:0] addr;
   } evt_t;

   logic [7:0]  qa_samp [$];
   logic [15:0] qb_samp [$];
   logic [22:0] qa_addr [$];
   logic [22:0] qb_addr [$];
   evt_t        q_evt [$];
   logic [7:0]  a_last = 8'h00;
   int          n_cmp = 0;
   int          n_bad = 0;

   function automatic logic [31:0] mem(input logic b, input logic [22:0] a);
      if (b) return 32'hBBBBAAAA;
      case (a)
         23'd4:   return 32'h44332211;
         23'd5:   return 32'h88776655;
         23'd6:   return 32'hCCBBAA99;
         default: return 32'hDEADBEEF;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic unexp(input string nm, input logic [31:0] act);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got %h, expected no output", nm, act);
   endtask

   // flash slave: wait_n waitrequest cycles, data one cycle after accept
   initial begin
      int          wcnt;
      logic        acc;
      logic [22:0] acc_addr;
      wcnt = 0;
      acc = 1'b0;
      acc_addr = '0;
      f_wr = 1'b1;
      f_rdv = 1'b0;
      f_rdata = '0;
      forever begin
         @(posedge inclk);
         #1;
         f_rdv = 1'b0;
         if (acc && reset_n) begin
            f_rdv = 1'b1;
            f_rdata = mem(sel_b, acc_addr);
         end
         acc = 1'b0;
         if (sel_b ? b_read : a_read) begin
            if (wcnt < wait_n) begin
               f_wr = 1'b1;
               wcnt++;
            end else begin
               f_wr = 1'b0;
               acc = 1'b1;
               acc_addr = sel_b ? b_addr : a_addr;
               wcnt = 0;
            end
         end else begin
            f_wr = 1'b1;
            wcnt = 0;
         end
      end
   end

   initial begin
      logic [7:0]  ea;
      logic [15:0] eb;
      logic [22:0] ad;
      evt_t        ev;
      forever begin
         @(negedge inclk);
         if (a_valid) begin
            if (qa_samp.size() == 0) unexp("a_sample", a_audio);
            else begin
               ea = qa_samp.pop_front();
               a_last = ea;
               chk("a_sample", a_audio, ea);
            end
         end
         if (a_read && f_wr && qa_addr.size() != 0)
            chk("a_addr_stable", a_addr, qa_addr[0]);
         if (a_read && !f_wr) begin
            if (qa_addr.size() == 0) unexp("a_read_addr", a_addr);
            else begin
               ad = qa_addr.pop_front();
               chk("a_read_addr", a_addr, ad);
            end
         end
         if (a_end || a_under) begin
            if (q_evt.size() == 0) unexp("a_event", {a_end, a_under});
            else begin
               ev = q_evt.pop_front();
               chk("a_end_pulse", a_end, ev.is_end);
               chk("a_underrun_pulse", a_under, !ev.is_end);
               if (ev.is_end) begin
                  chk("a_end_busy", a_busy, 0);
                  chk("a_end_addr", a_addr, ev.addr);
               end else begin
                  chk("a_underrun_audio", a_audio, a_last);
               end
            end
         end
         if (b_valid) begin
            if (qb_samp.size() == 0) unexp("b_sample", b_audio);
            else begin
               eb = qb_samp.pop_front();
               chk("b_sample", b_audio, eb);
            end
         end
         if (b_read && !f_wr) begin
            if (qb_addr.size() == 0) unexp("b_read_addr", b_addr);
            else begin
               ad = qb_addr.pop_front();
               chk("b_read_addr", b_addr, ad);
            end
         end
         if (b_end || b_under) unexp("b_event", {b_end, b_under});
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge inclk);
      #2;
   endtask

   task automatic wait_rdv();
      int k = 0;
      while (!f_rdv && k < 200) begin
         step();
         k++;
      end
      if (!f_rdv) unexp("wait_rdv_timeout", k);
      step();
   endtask

   task automatic wait_read_a();
      int k = 0;
      while (!a_read && k < 50) begin
         step();
         k++;
      end
      if (!a_read) unexp("wait_read_timeout", k);
   endtask

   task automatic tick_a(input logic [7:0] e);
      qa_samp.push_back(e);
      a_tick = 1'b1;
      step();
      a_tick = 1'b0;
      step();
   endtask

   task automatic tick_b(input logic [15:0] e);
      qb_samp.push_back(e);
      b_tick = 1'b1;
      step();
      b_tick = 1'b0;
      step();
   endtask

   task automatic restart_a();
      a_restart = 1'b1;
      step();
      a_restart = 1'b0;
   endtask

   // seq holds the expected samples in playout order, first in the MSB
   task automatic play_a(input logic [22:0] ad, input logic [31:0] seq);
      qa_addr.push_back(ad);
      wait_rdv();
      tick_a(seq[31:24]);
      tick_a(seq[23:16]);
      tick_a(seq[15:8]);
      tick_a(seq[7:0]);
   endtask

   task automatic push_evt(input logic is_end, input logic [22:0] ad);
      evt_t e;
      e.is_end = is_end;
      e.addr = ad;
      q_evt.push_back(e);
   endtask

   task automatic chk_reset_a();
      chk("rst_read", a_read, 0);
      chk("rst_addr", a_addr, 23'd4);
      chk("rst_audio", a_audio, 0);
      chk("rst_valid", a_valid, 0);
      chk("rst_end", a_end, 0);
      chk("rst_underrun", a_under, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_byteenable", a_be, 4'hF);
   endtask

   initial begin
      #1 reset_n = 1'b0;
      #2 chk_reset_a();
      step(2);
      reset_n = 1'b1;
      step();

      a_play = 1'b1;
      step();
      chk("play_to_read", a_read, 1);
      play_a(23'd4, 32'h11223344);
      wait_n = 0;
      play_a(23'd5, 32'h55667788);
      play_a(23'd6, 32'h99AABBCC);
      play_a(23'd4, 32'h11223344);
      play_a(23'd5, 32'h55667788);
      a_loop = 1'b0;
      push_evt(1'b1, 23'd4);
      play_a(23'd6, 32'h99AABBCC);
      play_a(23'd4, 32'h11223344);

      qa_addr.push_back(23'd5);
      wait_rdv();
      tick_a(8'h55);
      restart_a();
      tick_a(8'h66);
      tick_a(8'h77);
      tick_a(8'h88);
      play_a(23'd4, 32'h11223344);
      play_a(23'd5, 32'h55667788);

      qa_addr.push_back(23'd6);
      wait_rdv();
      tick_a(8'h99);
      restart_a();
      tick_a(8'hAA);
      tick_a(8'hBB);
      tick_a(8'hCC);

      a_dir = 1'b1;
      a_loop = 1'b1;
      play_a(23'd4, 32'h44332211);
      play_a(23'd6, 32'hCCBBAA99);
      play_a(23'd5, 32'h88776655);
      a_loop = 1'b0;
      wait_n = 10;
      push_evt(1'b1, 23'd6);
      play_a(23'd4, 32'h44332211);

      qa_addr.push_back(23'd6);
      wait_read_a();
      step();
      push_evt(1'b0, 23'd0);
      a_tick = 1'b1;
      step();
      a_tick = 1'b0;
      wait_rdv();
      tick_a(8'hCC);
      tick_a(8'hBB);
      a_play = 1'b0;
      tick_a(8'hAA);
      tick_a(8'h99);
      step(2);
      chk("stop_busy", a_busy, 0);
      chk("stop_addr", a_addr, 23'd5);

      a_dir = 1'b0;
      restart_a();
      chk("idle_restart_fwd", a_addr, 23'd4);
      a_dir = 1'b1;
      restart_a();
      chk("idle_restart_rev", a_addr, 23'd6);
      a_tick = 1'b1;
      step();
      a_tick = 1'b0;
      step(3);

      a_dir = 1'b0;
      a_play = 1'b1;
      wait_read_a();
      step();
      chk("pre_reset_read", a_read, 1);
      reset_n = 1'b0;
      #1 chk_reset_a();
      a_play = 1'b0;
      step(2);
      reset_n = 1'b1;
      step(2);

      sel_b = 1'b1;
      wait_n = 0;
      b_dir = 1'b1;
      b_restart = 1'b1;
      step();
      b_restart = 1'b0;
      chk("b_restart_rev", b_addr, 23'h7FFFF);
      qb_addr.push_back(23'h7FFFF);
      b_play = 1'b1;
      wait_rdv();
      tick_b(16'hBBBB);
      b_play = 1'b0;
      tick_b(16'hAAAA);
      step(3);
      chk("b_next_addr", b_addr, 23'h7FFFE);
      chk("b_busy", b_busy, 0);

      step(4);
      chk("a_samples_left", qa_samp.size(), 0);
      chk("a_addrs_left", qa_addr.size(), 0);
      chk("a_events_left", q_evt.size(), 0);
      chk("b_samples_left", qb_samp.size(), 0);
      chk("b_addrs_left", qb_addr.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/flash_sample_streamer.md
# flash_sample_streamer

- Streams audio samples from the Avalon-MM flash controller to the audio output path.
- Parametrised successor to the single-mode flash address generator: configurable sample width (8 or 16 bit) and address window.
- Adds forward/reverse playback, loop or one-shot end-of-window handling, a waitrequest/readdatavalid handshake, and underrun reporting.
- Sits between the flash controller and the audio codec feeder; its only timebase is the `inclk` domain.

## Interface
Parameters:
- `ADDR_W`, 23: flash word-address width.
- `SAMPLE_W`, 8: sample width, 8 or 16. Lanes per word N = 32/SAMPLE_W.
- `START_ADDR`, 0: first word address of the playback window.
- `END_ADDR`, 23'h7FFFF: last word address of the window. Must satisfy END_ADDR ≥ START_ADDR.

Ports:
- `inclk` in 1: the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `play` in 1: level; playback enabled.
- `direction` in 1: 0 = forward, 1 = reverse.
- `loop` in 1: 1 = wrap at window end; 0 = stop.
- `restart` in 1: one-cycle pulse; jump to the window start for the current direction.
- `sample_tick` in 1: one-`inclk` pulse per audio sample period, already synchronised.
- `flash_mem_read` out 1: Avalon read request.
- `flash_mem_address` out ADDR_W: word address.
- `flash_mem_byteenable` out 4: constant 4'hF.
- `flash_mem_waitrequest` in 1: Avalon waitrequest.
- `flash_mem_readdatavalid` in 1: read data valid.
- `flash_mem_readdata` in 32: read data.
- `audio_data` out SAMPLE_W: current sample, two's complement, held between ticks.
- `sample_valid` out 1: one-cycle pulse when `audio_data` updates.
- `end_reached` out 1: one-cycle pulse on one-shot stop.
- `underrun` out 1: one-cycle pulse when a tick is dropped.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
States:
- IDLE → REQ when `play`=1.
- REQ: `flash_mem_read`=1 with `flash_mem_address` stable. Leave when `flash_mem_waitrequest`=0, going to WAIT.
- WAIT: `flash_mem_read`=0. On `flash_mem_readdatavalid`, capture readdata into the word buffer, load the lane index, go to PLAY.
- PLAY: on each `sample_tick`, output lane[idx] to `audio_data` and pulse `sample_valid`.
  - Lane k = readdata[k*SAMPLE_W +: SAMPLE_W].
  - Forward: idx runs 0 → N-1. Reverse: idx runs N-1 → 0.
  - After the last lane is output, go to NEXT.
- NEXT: update the address, then go to REQ if `play`=1, else IDLE.

Address update in NEXT, in priority order:
1. Pending restart: forward → START_ADDR, reverse → END_ADDR.
2. Forward at END_ADDR: if `loop`, wrap to START_ADDR. Else set START_ADDR, pulse `end_reached`, go to IDLE regardless of `play`.
3. Reverse at START_ADDR: if `loop`, wrap to END_ADDR. Else set END_ADDR, pulse `end_reached`, go to IDLE.
4. Otherwise ±1, computed in ADDR_W bits.

Other rules:
- A `restart` pulse in any non-IDLE state sets a pending flag, applied in NEXT. The current word finishes. The flag clears in NEXT.
- `restart` in IDLE loads the start address immediately.
- `direction` is sampled when the lane index is loaded (WAIT → PLAY) and in NEXT. A change mid-word takes effect on the next word.
- `sample_tick` in REQ or WAIT with `play`=1 is dropped and pulses `underrun` on the following cycle.
- `sample_tick` in IDLE or NEXT is ignored with no underrun pulse.
- `play` falling mid-word: the current word finishes, then NEXT goes to IDLE.

## Timing
Reset values (asynchronous, applied immediately):
- State IDLE, `flash_mem_read`=0, `flash_mem_address`=START_ADDR.
- `audio_data`=0, `sample_valid`=0, `end_reached`=0, `underrun`=0, `busy`=0, restart flag clear, idx=0.
- Reset during REQ drops `flash_mem_read` without completing the handshake.

Latencies and handshake:
- `play` rise → `flash_mem_read` high: 1 cycle.
- REQ lasts 1 + (number of waitrequest-high cycles).
- `readdatavalid` → PLAY entered the next cycle. The first tick in PLAY updates `audio_data` the cycle after the tick.
- `sample_valid` coincides with the new `audio_data`.
- NEXT is exactly 1 cycle. Last tick of a word → next `flash_mem_read`: 2 cycles.
- `flash_mem_address` never changes while `flash_mem_read`=1 and `flash_mem_waitrequest`=1.

## Test plan
- **Forward, 8-bit:** SAMPLE_W=8, word 32'h44332211 at address 0, waitrequest 2 cycles. Four ticks → `audio_data` 11, 22, 33, 44; next read at address 1.
- **Reverse, 16-bit:** SAMPLE_W=16, direction=1, word 32'hBBBBAAAA. Two ticks → BBBB then AAAA; address decrements by 1.
- **Window wrap:** START_ADDR=4, END_ADDR=6, loop=1, forward → addresses 4, 5, 6, 4. With loop=0 → `end_reached` pulses after address 6; state IDLE; address 4.
- **Restart mid-word:** restart at forward address 5, lane 1 → remaining lanes of word 5 play, then next read at START_ADDR. Restart coinciding with END_ADDR and loop=0 → restart wins, no `end_reached`.
- **Underrun:** hold waitrequest 10 cycles and issue a tick during REQ → one `underrun` pulse; `audio_data` unchanged.
- **Reset:** assert `reset_n`=0 while `flash_mem_read`=1 → read drops the same cycle; all outputs at their reset values.
